// File: rtl/vga_stream_ctrl.sv
// vga_stream_ctrl: pixel-domain raster timing and show-ahead FIFO read sequencer.
// Holds video off until the FIFO is primed, aligns the start of streaming to a
// frame wrap, and detects FIFO underflow.
// Optional feature macro: VGA_AUTO_RESTART_EN (underflow -> FLUSH -> WAIT_FILL with
// a restart_req pulse). Undefined: underflow stays in STREAM, restart_req is 0.
// Ports:
//   pixel_clk, pixel_rst      clock, async active-high reset
//   fifo_full_sync            synchronized FIFO full flag
//   fifo_empty, fifo_rdata    FIFO empty flag and head word (RGB)
//   fifo_read                 FIFO pop (combinational)
//   hs, vs                    active-low syncs (registered)
//   blank                     1 = active video pixel (registered)
//   rgb                       pixel data (combinational)
//   frame_start               pulse while counters read (0,0)
//   restart_req               fetcher/FIFO restart pulse (registered)
//   underflow_cnt             saturating underflow event counter
//   state                     FSM state for debug
module vga_stream_ctrl #(
    parameter int          HDISP           = 800,
    parameter int          VDISP           = 480,
    parameter int          HFP             = 40,
    parameter int          HPULSE          = 48,
    parameter int          HBP             = 40,
    parameter int          VFP             = 13,
    parameter int          VPULSE          = 3,
    parameter int          VBP             = 29,
    parameter int          RESTART_CYCLES  = 4,
    parameter logic [23:0] UNDERFLOW_COLOR = 24'h000000
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst,
    input  logic        fifo_full_sync,
    input  logic        fifo_empty,
    input  logic [23:0] fifo_rdata,
    output logic        fifo_read,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic [23:0] rgb,
    output logic        frame_start,
    output logic        restart_req,
    output logic [15:0] underflow_cnt,
    output logic [1:0]  state
);

    localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
    localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
    localparam int PW     = $clog2(HTOTAL);
    localparam int LW     = $clog2(VTOTAL);

    localparam logic [PW-1:0] H_LAST   = PW'(HTOTAL - 1);
    localparam logic [PW-1:0] H_SYNC_S = PW'(HFP);
    localparam logic [PW-1:0] H_SYNC_E = PW'(HFP + HPULSE);
    localparam logic [PW-1:0] H_ACT    = PW'(HFP + HPULSE + HBP);
    localparam logic [LW-1:0] V_LAST   = LW'(VTOTAL - 1);
    localparam logic [LW-1:0] V_SYNC_S = LW'(VFP);
    localparam logic [LW-1:0] V_SYNC_E = LW'(VFP + VPULSE);
    localparam logic [LW-1:0] V_ACT    = LW'(VFP + VPULSE + VBP);

    localparam logic [1:0] ST_WAIT_FILL  = 2'd0;
    localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
    localparam logic [1:0] ST_STREAM     = 2'd2;
    localparam logic [1:0] ST_FLUSH      = 2'd3;

    logic [PW-1:0] pixel_cpt_q, pixel_cpt_d;
    logic [LW-1:0] line_cpt_q, line_cpt_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          blank_q, blank_d;
    logic          frame_start_q, frame_start_d;
    logic [1:0]    state_q, state_d;
    logic [15:0]   underflow_cnt_q, underflow_cnt_d;
    logic          pixel_last, line_last, wrap, underflow;

`ifdef VGA_AUTO_RESTART_EN
    localparam int FW = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(RESTART_CYCLES - 1);

    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic          restart_req_q, restart_req_d;
`endif

    // Counters free-run in every state so sync timing never glitches
    always_comb begin
        pixel_last  = (pixel_cpt_q == H_LAST);
        line_last   = (line_cpt_q == V_LAST);
        wrap        = pixel_last & line_last;
        pixel_cpt_d = pixel_last ? '0 : pixel_cpt_q + PW'(1);
        line_cpt_d  = line_cpt_q;
        if (pixel_last) begin
            line_cpt_d = line_last ? '0 : line_cpt_q + LW'(1);
        end
    end

    // Decode from current counters; outputs appear one cycle later
    always_comb begin
        hs_d = ~((pixel_cpt_q >= H_SYNC_S) && (pixel_cpt_q < H_SYNC_E));
        vs_d = ~((line_cpt_q >= V_SYNC_S) && (line_cpt_q < V_SYNC_E));
        blank_d = (line_cpt_q >= V_ACT) && (pixel_cpt_q >= H_ACT);
        // Registered, so it lands in the cycle the counters read (0,0)
        frame_start_d = wrap;
    end

    always_comb begin
        state_d         = state_q;
        underflow_cnt_d = underflow_cnt_q;
        fifo_read       = 1'b0;
        rgb             = '0;
        underflow       = 1'b0;
`ifdef VGA_AUTO_RESTART_EN
        flush_cnt_d     = '0;
`endif
        unique case (state_q)
            ST_WAIT_FILL: begin
                if (fifo_full_sync) begin
                    state_d = ST_WAIT_FRAME;
                end
            end
            ST_WAIT_FRAME: begin
                if (wrap) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (blank_q) begin
                    if (fifo_empty) begin
                        underflow = 1'b1;
                        rgb       = UNDERFLOW_COLOR;
`ifdef VGA_AUTO_RESTART_EN
                        state_d   = ST_FLUSH;
`endif
                    end else begin
                        fifo_read = 1'b1;
                        rgb       = fifo_rdata;
                    end
                end
            end
            ST_FLUSH: begin
`ifdef VGA_AUTO_RESTART_EN
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = ST_WAIT_FILL;
                end else begin
                    flush_cnt_d = flush_cnt_q + FW'(1);
                end
`else
                state_d = ST_WAIT_FILL;
`endif
            end
        endcase
        if (underflow && (underflow_cnt_q != 16'hFFFF)) begin
            underflow_cnt_d = underflow_cnt_q + 16'd1;
        end
    end

`ifdef VGA_AUTO_RESTART_EN
    // Registered copy of "next state is FLUSH" is high exactly while in FLUSH
    always_comb begin
        restart_req_d = (state_d == ST_FLUSH);
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            flush_cnt_q   <= '0;
            restart_req_q <= 1'b0;
        end else begin
            flush_cnt_q   <= flush_cnt_d;
            restart_req_q <= restart_req_d;
        end
    end

    assign restart_req = restart_req_q;
`else
    assign restart_req = 1'b0;
`endif

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            pixel_cpt_q     <= '0;
            line_cpt_q      <= '0;
            hs_q            <= 1'b1;
            vs_q            <= 1'b1;
            blank_q         <= 1'b0;
            frame_start_q   <= 1'b0;
            state_q         <= ST_WAIT_FILL;
            underflow_cnt_q <= '0;
        end else begin
            pixel_cpt_q     <= pixel_cpt_d;
            line_cpt_q      <= line_cpt_d;
            hs_q            <= hs_d;
            vs_q            <= vs_d;
            blank_q         <= blank_d;
            frame_start_q   <= frame_start_d;
            state_q         <= state_d;
            underflow_cnt_q <= underflow_cnt_d;
        end
    end

    assign hs            = hs_q;
    assign vs            = vs_q;
    assign blank         = blank_q;
    assign frame_start   = frame_start_q;
    assign underflow_cnt = underflow_cnt_q;
    assign state         = state_q;

endmodule

// File: tb/tb_vga_stream_ctrl.sv
// tb_vga_stream_ctrl: directed bench for vga_stream_ctrl.
// Small raster: 14 pixels x 7 lines = 98 cycles per frame.
module tb_vga_stream_ctrl;

    logic        pixel_clk = 1'b0;
    logic        pixel_rst = 1'b1;
    logic        fifo_full_sync = 1'b0;
    logic        fifo_empty = 1'b0;
    logic [23:0] fifo_rdata = 24'h100000;
    logic        fifo_read;
    logic        hs, vs, blank;
    logic [23:0] rgb;
    logic        frame_start;
    logic        restart_req;
    logic [15:0] underflow_cnt;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic pop;

    localparam logic [47:0] RST_VEC =
        {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 24'h0};

    vga_stream_ctrl #(
        .HDISP(8), .VDISP(4),
        .HFP(2), .HPULSE(2), .HBP(2),
        .VFP(1), .VPULSE(1), .VBP(1),
        .RESTART_CYCLES(4),
        .UNDERFLOW_COLOR(24'h000000)
    ) dut (
        .pixel_clk     (pixel_clk),
        .pixel_rst     (pixel_rst),
        .fifo_full_sync(fifo_full_sync),
        .fifo_empty    (fifo_empty),
        .fifo_rdata    (fifo_rdata),
        .fifo_read     (fifo_read),
        .hs            (hs),
        .vs            (vs),
        .blank         (blank),
        .rgb           (rgb),
        .frame_start   (frame_start),
        .restart_req   (restart_req),
        .underflow_cnt (underflow_cnt),
        .state         (state)
    );

    always #5 pixel_clk = ~pixel_clk;

    function automatic logic [47:0] out_vec();
        return {hs, vs, blank, frame_start, restart_req,
                underflow_cnt, state, fifo_read, rgb};
    endfunction

    // One clock; the FIFO model advances its head word on a pop
    task automatic tick();
        #1;
        pop = fifo_read;
        @(posedge pixel_clk);
        #1;
        if (pop) fifo_rdata = fifo_rdata + 24'd1;
        cyc++;
    endtask

    task automatic run_to(input int tgt);
        for (int i = 0; i < 98 && (cyc % 98) != tgt; i++) tick();
    endtask

    task automatic test_reset();
        logic [1:0] exp_sync;
        int px;
        tick();
        tick();
        total++;
        if (out_vec() !== RST_VEC) begin
            bad++;
            $display("FAIL reset_vals got=%h exp=%h", out_vec(), RST_VEC);
        end
        #2;
        pixel_rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 31; i++) begin
            #1;
            px = cyc % 14;
            exp_sync = {!(px == 3 || px == 4), !(cyc >= 15 && cyc <= 28)};
            total++;
            if ({hs, vs} !== exp_sync) begin
                bad++;
                $display("FAIL reset_sync cyc=%0d got=%b exp=%b",
                         cyc, {hs, vs}, exp_sync);
            end
            tick();
        end
    endtask

    task automatic test_never_primed();
        logic [30:0] exp, got;
        int g, p;
        fifo_full_sync = 1'b0;
        fifo_rdata = 24'hABCDEF;
        for (int i = 0; i < 294; i++) begin
            #1;
            g = cyc % 98;
            p = (g + 97) % 98;
            exp = {!((cyc % 14) == 3 || (cyc % 14) == 4),
                   !(g >= 15 && g <= 28),
                   (p / 14 >= 3) && (p % 14 >= 6),
                   (g == 0),
                   2'd0, 1'b0, 24'h0};
            got = {hs, vs, blank, frame_start, state, fifo_read, rgb};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL idle cyc=%0d got=%h exp=%h", cyc, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_priming();
        int pops;
        logic [23:0] exp_rgb;
        fifo_rdata = 24'h100000;
        fifo_empty = 1'b0;
        run_to(50);
        fifo_full_sync = 1'b1;
        #1;
        total++;
        if (state !== 2'd0) begin
            bad++;
            $display("FAIL prime_pre got=%0d exp=0", state);
        end
        tick();
        fifo_full_sync = 1'b0;
        for (int i = 0; i < 98 && (cyc % 98) != 0; i++) begin
            #1;
            total++;
            if ({state, fifo_read, rgb} !== {2'd1, 1'b0, 24'h0}) begin
                bad++;
                $display("FAIL prime_wait cyc=%0d got=%h exp=%h",
                         cyc, {state, fifo_read, rgb}, {2'd1, 1'b0, 24'h0});
            end
            tick();
        end
        #1;
        total++;
        if ({state, blank, fifo_read, frame_start} !== {2'd2, 3'b111}) begin
            bad++;
            $display("FAIL prime_first got=%b exp=%b",
                     {state, blank, fifo_read, frame_start}, {2'd2, 3'b111});
        end
        pops = 0;
        for (int i = 0; i < 98; i++) begin
            #1;
            exp_rgb = blank ? fifo_rdata : 24'h0;
            total++;
            if ({fifo_read, rgb} !== {blank, exp_rgb}) begin
                bad++;
                $display("FAIL stream cyc=%0d got=%h exp=%h",
                         cyc, {fifo_read, rgb}, {blank, exp_rgb});
            end
            if (fifo_read) pops++;
            tick();
        end
        total++;
        if (pops != 32 || state !== 2'd2) begin
            bad++;
            $display("FAIL pops got=%0d/%0d exp=32/2", pops, state);
        end
    endtask

`ifdef VGA_AUTO_RESTART_EN
    task automatic test_underflow();
        int hi;
        run_to(53);
        fifo_empty = 1'b1;
        #1;
        total++;
        if ({state, blank, fifo_read, rgb, underflow_cnt} !==
            {2'd2, 1'b1, 1'b0, 24'h0, 16'd0}) begin
            bad++;
            $display("FAIL uf_cycle got=%h", {state, blank, fifo_read, rgb});
        end
        tick();
        fifo_empty = 1'b0;
        total++;
        if ({state, restart_req, underflow_cnt} !== {2'd3, 1'b1, 16'd1}) begin
            bad++;
            $display("FAIL uf_flush got=%h exp=%h",
                     {state, restart_req, underflow_cnt}, {2'd3, 1'b1, 16'd1});
        end
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (restart_req) hi++;
            total++;
            if ({fifo_read, rgb} !== 25'h0) begin
                bad++;
                $display("FAIL uf_quiet got=%h exp=0", {fifo_read, rgb});
            end
            tick();
        end
        total++;
        if (hi != 4 || state !== 2'd0 || restart_req !== 1'b0) begin
            bad++;
            $display("FAIL uf_restart got=%0d/%0d exp=4/0", hi, state);
        end
    endtask
`else
    task automatic test_underflow();
        run_to(53);
        fifo_empty = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({state, fifo_read, rgb, underflow_cnt, restart_req} !==
                {2'd2, 1'b0, 24'h0, 16'(i), 1'b0}) begin
                bad++;
                $display("FAIL uf_stay i=%0d got=%h", i,
                         {state, fifo_read, rgb, underflow_cnt, restart_req});
            end
            tick();
        end
        fifo_empty = 1'b0;
        #1;
        total++;
        if ({state, fifo_read, underflow_cnt} !== {2'd2, 1'b1, 16'd3}) begin
            bad++;
            $display("FAIL uf_resume got=%h exp=%h",
                     {state, fifo_read, underflow_cnt}, {2'd2, 1'b1, 16'd3});
        end
        for (int i = 0; i < 40; i++) begin
            #1;
            total++;
            if (restart_req !== 1'b0) begin
                bad++;
                $display("FAIL uf_norestart got=%b exp=0", restart_req);
            end
            tick();
        end
    endtask
`endif

    task automatic test_mid_reset();
        run_to(10);
        fifo_full_sync = 1'b1;
        tick();
        fifo_full_sync = 1'b0;
        run_to(0);
        run_to(60);
        total++;
        if (state !== 2'd2) begin
            bad++;
            $display("FAIL mr_pre got=%0d exp=2", state);
        end
        #2;
        pixel_rst = 1'b1;
        #1;
        total++;
        if (out_vec() !== RST_VEC) begin
            bad++;
            $display("FAIL mr_stream got=%h exp=%h", out_vec(), RST_VEC);
        end
        tick();
        pixel_rst = 1'b0;
        cyc = 0;
        tick();
        tick();
        total++;
        if (hs !== 1'b1) begin
            bad++;
            $display("FAIL mr_hs2 got=%b exp=1", hs);
        end
        tick();
        total++;
        if (hs !== 1'b0) begin
            bad++;
            $display("FAIL mr_hs3 got=%b exp=0", hs);
        end
`ifdef VGA_AUTO_RESTART_EN
        run_to(10);
        fifo_full_sync = 1'b1;
        tick();
        fifo_full_sync = 1'b0;
        run_to(0);
        run_to(53);
        fifo_empty = 1'b1;
        tick();
        fifo_empty = 1'b0;
        tick();
        total++;
        if ({state, restart_req} !== {2'd3, 1'b1}) begin
            bad++;
            $display("FAIL mr_inflush got=%b exp=111", {state, restart_req});
        end
        #2;
        pixel_rst = 1'b1;
        #1;
        total++;
        if (out_vec() !== RST_VEC) begin
            bad++;
            $display("FAIL mr_flush got=%h exp=%h", out_vec(), RST_VEC);
        end
        tick();
        pixel_rst = 1'b0;
        cyc = 0;
`endif
    endtask

    initial begin
        test_reset();
        test_never_primed();
        test_priming();
        test_underflow();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_stream_ctrl.md
# vga_stream_ctrl

Pixel-domain sequencer for the VGA display path. It generates the raster timing (HS/VS/BLANK) and decides when the async pixel FIFO is read. Output is held off until the FIFO has been primed, then aligned to a frame boundary. FIFO underflow is detected, and the SDRAM fetcher is told to restart. It sits between the CDC FIFO read port and `video_if`, and replaces free-running read logic.

## Interface
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- HFP / HPULSE / HBP, 40 / 48 / 40, horizontal front porch / sync / back porch (pixels)
- VFP / VPULSE / VBP, 13 / 3 / 29, vertical front porch / sync / back porch (lines)
- RESTART_CYCLES, 4, length of restart_req pulse (≥1)
- UNDERFLOW_COLOR, 24'h000000, RGB driven on an underflowed active pixel

Ports:
- pixel_clk  in  1  pixel clock
- pixel_rst  in  1  reset, asynchronous, active-high
- fifo_full_sync  in  1  FIFO full flag, already 2-flop synchronized into pixel_clk
- fifo_empty  in  1  FIFO empty flag (read domain, show-ahead FIFO)
- fifo_rdata  in  24  FIFO head word, RGB
- fifo_read  out  1  FIFO pop, combinational
- hs  out  1  horizontal sync, active-low, registered
- vs  out  1  vertical sync, active-low, registered
- blank  out  1  1 = active video pixel (video_if.BLANK semantics), registered
- rgb  out  24  pixel data, combinational
- frame_start  out  1  one-cycle pulse, first cycle of each frame
- restart_req  out  1  fetcher/FIFO restart pulse; CDC handled by the receiver
- underflow_cnt  out  16  saturating underflow counter
- state  out  2  FSM state, for debug

## Operation
- Counters:
  - pixel_cpt runs 0..HTOTAL-1, with HTOTAL = HFP+HPULSE+HBP+HDISP.
  - line_cpt runs 0..VTOTAL-1 and advances when pixel_cpt wraps.
  - Both counters run in every state.
  - Widths are $clog2 of the totals.
- Timing decode, registered from the current counter values:
  - hs = 0 iff HFP ≤ pixel_cpt < HFP+HPULSE.
  - vs = 0 iff VFP ≤ line_cpt < VFP+VPULSE.
  - blank = 1 iff line_cpt ≥ VFP+VPULSE+VBP and pixel_cpt ≥ HFP+HPULSE+HBP.
- frame_start is registered and is 1 exactly in the cycle where the counters read (0,0).
- FSM:
  - WAIT_FILL (0): fifo_read = 0, rgb = 0. On fifo_full_sync = 1, go to WAIT_FRAME.
  - WAIT_FRAME (1): fifo_read = 0, rgb = 0. Further full/not-full changes are ignored. Go to STREAM on the edge where the counters wrap from (HTOTAL-1, VTOTAL-1) to (0,0).
  - STREAM (2), no underflow: fifo_read = blank & ~fifo_empty. rgb = fifo_rdata when blank, else 0.
  - STREAM, underflow (blank = 1 and fifo_empty = 1): fifo_read = 0, rgb = UNDERFLOW_COLOR, underflow_cnt += 1 (saturates at 16'hFFFF), then go to FLUSH.
  - FLUSH (3): restart_req = 1 for exactly RESTART_CYCLES cycles, then go to WAIT_FILL. fifo_read = 0, rgb = 0.
- restart_req is registered; it is high only in FLUSH.
- The receiver zeroes the fetch address and clears the FIFO on restart_req, so the first word after refill is pixel (0,0).
- Exactly HDISP*VDISP pops occur per frame fully spent in STREAM with no underflow.

## Timing
- Reset values:
  - hs = 1, vs = 1, blank = 0, frame_start = 0, restart_req = 0, underflow_cnt = 0, state = WAIT_FILL.
  - Both counters = 0.
  - fifo_read = 0 and rgb = 0 follow combinationally from state = WAIT_FILL.
- Decode latency: the registered outputs lag the counters by 1 cycle. fifo_read and rgb are aligned to the registered blank (0 extra cycles).
- Underflow on the last active pixel of a frame still enters FLUSH; there is no carry into the next frame.
- fifo_full_sync asserting in the same cycle as the frame wrap, while in WAIT_FILL: go to WAIT_FRAME only. STREAM starts at the next wrap.
- pixel_rst mid-operation: all outputs and state return to their reset values immediately. A FLUSH pulse in progress is truncated.

## Configuration
- VGA_AUTO_RESTART_EN defined: underflow behaviour as above (STREAM → FLUSH → WAIT_FILL; underflow_cnt counts events).
- VGA_AUTO_RESTART_EN undefined:
  - FLUSH is unreachable; restart_req is tied to 0.
  - An underflow stays in STREAM: that cycle outputs UNDERFLOW_COLOR with no pop.
  - underflow_cnt increments on every underflowed active pixel (saturating).

## Test plan
Bench parameters: HDISP=8, VDISP=4, HFP=HPULSE=HBP=2, VFP=VPULSE=VBP=1. This gives HTOTAL=14 and VTOTAL=7.

- Reset check: assert pixel_rst → all reset values above hold. After release, hs is low in cycles 3–4 of each 14-cycle line, and vs is low for 14 cycles starting at cycle 15.
- Never primed: fifo_full_sync = 0 for 3 frames → state stays 0, fifo_read never 1, rgb = 0, hs/vs keep toggling.
- Priming: pulse fifo_full_sync mid-frame → state 1 until the counters reach (0,0), then 2. The first fifo_read coincides with the first blank = 1. Exactly 32 pops per frame; rgb equals fifo_rdata.
- Underflow with macro: fifo_empty = 1 on the 5th active pixel → no pop, rgb = 24'h000000, underflow_cnt = 1, restart_req high exactly 4 cycles, then state 0.
- Underflow without macro: same stimulus, empty for 3 active cycles → state remains 2, underflow_cnt = 3, restart_req never 1, popping resumes when empty drops.
- Mid-stream reset: assert pixel_rst during STREAM, and again during FLUSH → immediate reset values, restart_req drops the same cycle.
